// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, device address and the
// OV7670 register defaults that the register file resets and COM7-restores to.
package sccb_pkg;

    localparam logic [6:0] DEV_ID_DEF = 7'h21;
    localparam logic [7:0] COM7_ADDR  = 8'h12;
    localparam logic [7:0] COM7_RST   = 8'h80;

    // PID/VER and MIDH/MIDL: the only non-zero defaults, and read-only
    localparam int NUM_DEF = 4;
    localparam logic [NUM_DEF-1:0][7:0] DEF_ADDR = {8'h1D, 8'h1C, 8'h0B, 8'h0A};
    localparam logic [NUM_DEF-1:0][7:0] DEF_VAL  = {8'hA2, 8'h7F, 8'h73, 8'h76};

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_IGNORE
    } sccb_state_t;

    function automatic logic [7:0] reg_default(input logic [7:0] a);
        reg_default = 8'h00;
        for (int k = 0; k < NUM_DEF; k++)
            if (DEF_ADDR[k] == a) reg_default = DEF_VAL[k];
    endfunction

    function automatic logic is_ro(input logic [7:0] a);
        is_ro = 1'b0;
        for (int k = 0; k < NUM_DEF; k++)
            if (DEF_ADDR[k] == a) is_ro = 1'b1;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// SIOC/SIOD synchronizers with SIOC edge and START/STOP detection.
// Event outputs are combinational off registered lines; consumers register them.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl;

    // Reset to the idle-high bus level so releasing reset never fakes an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign o_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    // SIOD may only move with SIOC held high across both samples
    assign o_start    = r_sda_d & ~o_sda & w_scl & r_scl_d;
    assign o_stop     = ~r_sda_d & o_sda & w_scl & r_scl_d;

endmodule

// File: rtl/sccb_responder.sv
// OV7670-style SCCB target: decodes 3-phase/2-phase writes and 2-phase reads
// against a 256x8 register file; pulls SIOD low only on SIOC fall.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = DEV_ID_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte, w_rd_byte;
    sccb_state_t r_state;
    logic [7:0]  r_shift, r_ptr;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic [7:0]  r_regs [256];

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETN),
        .i_scl      (sioc_i),
        .i_sda      (siod_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
            r_shift <= 8'h00;
            r_ptr   <= 8'h00;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            siod_oe <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (w_stop) begin
                r_state <= S_IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (w_start) begin
                r_state <= S_ID;
                r_cnt   <= 4'd0;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
            end else if (w_scl_rise && r_cnt != 4'd8 &&
                         (r_state inside {S_ID, S_SUB, S_WDATA, S_RDATA})) begin
                r_shift <= w_byte;
                r_cnt   <= r_cnt + 4'd1;
                // Pointer load and commit happen on the rise of the 8th bit
                if (r_cnt == 4'd7 && r_state == S_SUB)
                    r_ptr <= w_byte;
                if (r_cnt == 4'd7 && r_state == S_WDATA) begin
                    wr_stb  <= 1'b1;
                    wr_addr <= r_ptr;
                    wr_data <= w_byte;
                end
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ID: if (r_cnt == 4'd8) begin
                        r_cnt <= 4'd0;
                        if (r_shift[7:1] == DEV_ID) begin
                            r_state <= S_ID_ACK;
                            r_rd    <= r_shift[0];
                            siod_oe <= 1'b1;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                    S_ID_ACK: begin
                        r_state <= r_rd ? S_RDATA : S_SUB;
                        siod_oe <= r_rd ? ~w_rd_byte[7] : 1'b0;
                    end
                    S_SUB: if (r_cnt == 4'd8) begin
                        r_state <= S_SUB_ACK;
                        r_cnt   <= 4'd0;
                        siod_oe <= 1'b1;
                    end
                    S_SUB_ACK: begin
                        r_state <= S_WDATA;
                        siod_oe <= 1'b0;
                    end
                    S_WDATA: if (r_cnt == 4'd8) begin
                        r_state <= S_WDATA_ACK;
                        siod_oe <= 1'b1;
                    end
                    S_WDATA_ACK: begin
                        r_state <= S_IGNORE;
                        siod_oe <= 1'b0;
                    end
                    S_RDATA: begin
                        if (r_cnt == 4'd8) begin
                            r_state <= S_IGNORE;
                            siod_oe <= 1'b0;
                        end else begin
                            siod_oe <= ~w_rd_byte[3'd7 - r_cnt[2:0]];
                        end
                    end
                    default: siod_oe <= 1'b0;
                endcase
            end
        end
    end

    // Register file updates in the wr_stb cycle; COM7 soft reset reloads defaults
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < 256; i++) r_regs[i] <= reg_default(8'(i));
        end else if (wr_stb) begin
            if (wr_addr == COM7_ADDR && wr_data == COM7_RST) begin
                for (int i = 0; i < 256; i++) r_regs[i] <= reg_default(8'(i));
            end else if (!is_ro(wr_addr)) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

endmodule
